uart_word_tx: RTL

- Serializes one NBITS_D-bit word into NBITS_D/DBIT consecutive UART frames on o_tx.
- Order is least-significant byte first. The transmit side of the two-byte result link that the BIP uses to report data to the host.
- Frames are 8N1-style, timed by the 16x oversampling tick from mod_m_counter.
- Output is bit-compatible with uart_rx configured with the same DBIT/SB_TICK.

---
 rtl/uart_word_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// Word-to-UART serializer: sends an NBITS_D-bit word as NBITS_D/DBIT
// consecutive 8N1 frames, least-significant byte first.
module uart_word_tx #(
    parameter int NBITS_D = 16,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_valid,
    input  logic [NBITS_D-1:0] i_data,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_done
);

    localparam int NFRM = NBITS_D / DBIT;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int BW   = (NFRM > 1) ? $clog2(NFRM) : 1;

    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NFRM - 1);
    localparam logic [3:0]    S_LAST = 4'(SB_TICK - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]         state;
    logic [3:0]         s;
    logic [NW-1:0]      n;
    logic [BW-1:0]      b;
    logic [NBITS_D-1:0] word;
    logic [DBIT-1:0]    shreg;
    logic [DBIT-1:0]    shreg_nx;
    logic [NBITS_D-1:0] word_nx;
    logic               tx_q;
    logic               ready_q;
    logic               done_q;

    assign shreg_nx = shreg >> 1;
    // Next frame's byte is taken from the held word, indexed by b
    assign word_nx  = word >> (DBIT * (int'(b) + 1));

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            word    <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        word    <= i_data;
                        shreg   <= i_data[DBIT-1:0];
                        s       <= '0;
                        n       <= '0;
                        b       <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (s == 4'd15) begin
                            s     <= '0;
                            n     <= '0;
                            tx_q  <= shreg[0];
                            state <= DATA;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (s == 4'd15) begin
                            s     <= '0;
                            shreg <= shreg_nx;
                            if (n == N_LAST) begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end else begin
                                n    <= n + 1'b1;
                                tx_q <= shreg_nx[0];
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (i_s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (b != B_LAST) begin
                                b     <= b + 1'b1;
                                shreg <= word_nx[DBIT-1:0];
                                tx_q  <= 1'b0;
                                state <= START;
                            end else begin
                                done_q  <= 1'b1;
                                ready_q <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
